// File: rtl/cc_cond_unit_pkg.sv
// Shared Y86 instruction/condition encodings and condition-code reset value.
package cc_cond_unit_pkg;

  localparam logic [3:0] ICODE_CMOVXX = 4'd2;
  localparam logic [3:0] ICODE_OPQ    = 4'd6;
  localparam logic [3:0] ICODE_JXX    = 4'd7;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  // {zf,sf,of}
  localparam logic [2:0] CC_RST_DEFAULT = 3'b100;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// Combinational decode of a jXX/cmovXX condition against the stored flags.
// Undefined condition codes (ifun > 6) give cnd_raw=0 and raise bad_ifun.
module cond_eval
  import cc_cond_unit_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  output logic       cnd_raw,
  output logic       bad_ifun
);

  logic lt;

  assign lt = sf ^ of;

  always_comb begin
    cnd_raw  = 1'b0;
    bad_ifun = 1'b0;
    case (ifun)
      C_ALWAYS: cnd_raw = 1'b1;
      C_LE:     cnd_raw = lt | zf;
      C_L:      cnd_raw = lt;
      C_E:      cnd_raw = zf;
      C_NE:     cnd_raw = ~zf;
      C_GE:     cnd_raw = ~lt;
      C_G:      cnd_raw = ~lt & ~zf;
      default:  bad_ifun = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_cond_unit.sv
// Execute-stage condition-code register plus jXX/cmovXX condition evaluation.
// Flags update one cycle after an OPq; cnd always reads the registered flags.
module cc_cond_unit
  import cc_cond_unit_pkg::*;
#(
  parameter int         W      = 64,
  parameter logic [2:0] CC_RST = CC_RST_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic         stat_ok,
  input  logic [W-1:0] alu_out,
  input  logic         alu_ovf,
  input  logic         hold,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         cnd,
  output logic         cond_err
);

  cc_t  cc_q;
  cc_t  cc_d;
  logic set_cc;
  logic is_cond;
  logic cnd_raw;
  logic bad_ifun;

  assign set_cc = (icode == ICODE_OPQ) & stat_ok & ~hold;

  // alu_out is only looked at under set_cc, so junk on it otherwise is ignored.
  always_comb begin
    cc_d = cc_q;
    if (set_cc) begin
      cc_d.zf = (alu_out == '0);
      cc_d.sf = alu_out[W-1];
      cc_d.of = alu_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q <= cc_t'(CC_RST);
    end else begin
      cc_q <= cc_d;
    end
  end

  cond_eval u_cond_eval (
    .ifun     (ifun),
    .zf       (cc_q.zf),
    .sf       (cc_q.sf),
    .of       (cc_q.of),
    .cnd_raw  (cnd_raw),
    .bad_ifun (bad_ifun)
  );

  assign is_cond  = (icode == ICODE_CMOVXX) | (icode == ICODE_JXX);
  assign cnd      = is_cond & ~bad_ifun & cnd_raw;
  assign cond_err = is_cond & bad_ifun;

  assign zf = cc_q.zf;
  assign sf = cc_q.sf;
  assign of = cc_q.of;

endmodule

// File: tb/tb_cc_cond_unit.sv
// Directed-vector bench for cc_cond_unit with hand-computed flag and cnd values.
module tb_cc_cond_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   icode;
  logic [3:0]   ifun;
  logic         stat_ok;
  logic [W-1:0] alu_out;
  logic         alu_ovf;
  logic         hold;
  logic         zf, sf, of, cnd, cond_err;

  int n_checks = 0;
  int n_errors = 0;

  cc_cond_unit #(.W(W), .CC_RST(3'b100)) dut (
    .clk      (clk),
    .rst      (rst),
    .icode    (icode),
    .ifun     (ifun),
    .stat_ok  (stat_ok),
    .alu_out  (alu_out),
    .alu_ovf  (alu_ovf),
    .hold     (hold),
    .zf       (zf),
    .sf       (sf),
    .of       (of),
    .cnd      (cnd),
    .cond_err (cond_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn);
    icode = ic;
    ifun  = fn;
    #1;
  endtask

  task automatic opq(input logic [W-1:0] res, input logic ovf);
    icode   = 4'd6;
    ifun    = 4'd0;
    alu_out = res;
    alu_ovf = ovf;
    tick();
  endtask

  initial begin
    rst = 1'b1; icode = 4'd0; ifun = 4'd0; stat_ok = 1'b1;
    alu_out = '0; alu_ovf = 1'b0; hold = 1'b0;
    tick();
    rst = 1'b0;

    // reset flags
    chk("rst_flags", {5'd0, zf, sf, of}, 8'b100);
    drive(4'd7, 4'd3); chk("rst_je", {7'd0, cnd}, 8'd1);
    chk("rst_je_err", {7'd0, cond_err}, 8'd0);
    drive(4'd0, 4'd0); chk("nop_cnd", {7'd0, cnd}, 8'd0);

    // positive result 11-4
    icode = 4'd6; ifun = 4'd0; alu_out = 64'd7; alu_ovf = 1'b0; #1;
    chk("opq_cnd0", {7'd0, cnd}, 8'd0);
    tick();
    chk("pos_flags", {5'd0, zf, sf, of}, 8'b000);
    drive(4'd7, 4'd6); chk("pos_jg", {7'd0, cnd}, 8'd1);
    drive(4'd7, 4'd1); chk("pos_jle", {7'd0, cnd}, 8'd0);
    drive(4'd2, 4'd4); chk("pos_cmovne", {7'd0, cnd}, 8'd1);

    // MAX-(-1): overflow to MIN
    opq(64'h8000_0000_0000_0000, 1'b1);
    chk("ovf_flags", {5'd0, zf, sf, of}, 8'b011);
    drive(4'd7, 4'd2); chk("ovf_jl", {7'd0, cnd}, 8'd0);
    drive(4'd7, 4'd5); chk("ovf_jge", {7'd0, cnd}, 8'd1);
    drive(4'd2, 4'd1); chk("ovf_cmovle", {7'd0, cnd}, 8'd0);

    // blocked updates
    hold = 1'b1;
    opq(64'd0, 1'b0);
    chk("hold_flags", {5'd0, zf, sf, of}, 8'b011);
    hold = 1'b0; stat_ok = 1'b0;
    opq(64'd0, 1'b0);
    chk("statok_flags", {5'd0, zf, sf, of}, 8'b011);
    stat_ok = 1'b1;

    // bad condition codes and non-conditional icodes
    drive(4'd2, 4'd9); chk("cmov9_cnd", {7'd0, cnd}, 8'd0);
    chk("cmov9_err", {7'd0, cond_err}, 8'd1);
    drive(4'd7, 4'd7); chk("j7_err", {7'd0, cond_err}, 8'd1);
    drive(4'd6, 4'd9); chk("opq9_cnd", {7'd0, cnd}, 8'd0);
    chk("opq9_err", {7'd0, cond_err}, 8'd0);
    drive(4'd2, 4'd0); chk("cmov_always", {7'd0, cnd}, 8'd1);

    // back-to-back: zero result then je
    opq(64'd0, 1'b0);
    drive(4'd7, 4'd3); chk("b2b_je", {7'd0, cnd}, 8'd1);
    alu_out = 64'd5; #1;
    chk("nobypass_je", {7'd0, cnd}, 8'd1);
    tick();
    chk("jxx_noupd", {5'd0, zf, sf, of}, 8'b100);

    // MIN-MIN: zero result, ovf taken as given
    opq(64'd0, 1'b1);
    chk("zero_ovf_flags", {5'd0, zf, sf, of}, 8'b101);
    drive(4'd7, 4'd2); chk("zero_ovf_jl", {7'd0, cnd}, 8'd1);
    drive(4'd7, 4'd6); chk("zero_ovf_jg", {7'd0, cnd}, 8'd0);

    // reset drops a pending OPq
    rst = 1'b1;
    opq(64'd5, 1'b0);
    chk("rst_drop", {5'd0, zf, sf, of}, 8'b100);
    rst = 1'b0;
    opq(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("neg_flags", {5'd0, zf, sf, of}, 8'b010);
    rst = 1'b1; hold = 1'b1;
    opq(64'd0, 1'b0);
    chk("rst_over_hold", {5'd0, zf, sf, of}, 8'b100);
    rst = 1'b0; hold = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
